// File: rtl/axi_lite_mem_disp_pkg.sv
// Shared definitions for the AXI-Lite memory/display slave: response codes,
// channel FSM states and the seven-segment encoder.
package axi_disp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Active-low segments, bit order a..g,dp from MSB; dp always off.
  function automatic logic [7:0] seg7_encode(input logic [3:0] nibble);
    case (nibble)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return 8'h11;
      4'hB: return 8'hC1;
      4'hC: return 8'h63;
      4'hD: return 8'h85;
      4'hE: return 8'h61;
      default: return 8'h71;
    endcase
  endfunction

endpackage

// File: rtl/axi_lite_mem_disp_seg7_digit.sv
// One seven-segment digit: combinational nibble-to-segment decode.
module seg7_digit
  import axi_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = seg7_encode(nibble);

endmodule

// File: rtl/axi_lite_mem_disp.sv
// AXI-Lite register-file slave with independent read/write channels and a
// seven-segment display showing the last successfully read word.
module axi_lite_mem_disp
  import axi_disp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ms_awvalid,
  output logic                    sm_awready,
  input  logic [ADDR_W-1:0]       ms_awaddr,
  input  logic                    ms_wvalid,
  output logic                    sm_wready,
  input  logic [DATA_W-1:0]       ms_wdata,
  output logic                    sm_bvalid,
  input  logic                    ms_bready,
  output logic [1:0]              sm_bresp,
  input  logic                    ms_arvalid,
  output logic                    sm_arready,
  input  logic [ADDR_W-1:0]       ms_araddr,
  output logic                    sm_rvalid,
  input  logic                    ms_rready,
  output logic [DATA_W-1:0]       sm_rdata,
  output logic [1:0]              sm_rresp,
  output logic [8*(DATA_W/4)-1:0] disp_hex
);

  localparam int DIGITS = DATA_W / 4;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] aw_addr_q, c_addr;
  logic [DATA_W-1:0] w_data_q, c_data;
  logic              commit, awready_s, wready_s;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q, disp_q;
  logic              ar_hs, r_hs;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  // The completing handshake takes its half from the bus, the other half
  // from whichever latch the earlier handshake filled.
  always_comb begin
    w_next    = w_state;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    commit    = 1'b0;
    c_addr    = aw_addr_q;
    c_data    = w_data_q;
    case (w_state)
      W_IDLE: begin
        awready_s = 1'b1;
        wready_s  = 1'b1;
        if (ms_awvalid && ms_wvalid) begin
          commit = 1'b1;
          c_addr = ms_awaddr;
          c_data = ms_wdata;
          w_next = W_RESP;
        end else if (ms_awvalid) begin
          w_next = W_DATA;
        end else if (ms_wvalid) begin
          w_next = W_ADDR;
        end
      end
      W_ADDR: begin
        awready_s = 1'b1;
        if (ms_awvalid) begin
          commit = 1'b1;
          c_addr = ms_awaddr;
          w_next = W_RESP;
        end
      end
      W_DATA: begin
        wready_s = 1'b1;
        if (ms_wvalid) begin
          commit = 1'b1;
          c_data = ms_wdata;
          w_next = W_RESP;
        end
      end
      default: begin
        if (ms_bready) w_next = W_IDLE;
      end
    endcase
  end

  assign sm_awready = awready_s && reset_n;
  assign sm_wready  = wready_s && reset_n;
  assign sm_bvalid  = (w_state == W_RESP);
  assign sm_bresp   = bresp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && ms_awvalid) aw_addr_q <= ms_awaddr;
      if (w_state == W_IDLE && ms_wvalid)  w_data_q  <= ms_wdata;
      if (commit) bresp_q <= in_range(c_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (commit && in_range(c_addr)) begin
      mem[c_addr] <= c_data;
    end
  end

  assign ar_hs = (r_state == R_IDLE) && ms_arvalid;
  assign r_hs  = (r_state == R_DATA) && ms_rready;

  always_comb begin
    r_next = r_state;
    if (ar_hs)     r_next = R_DATA;
    else if (r_hs) r_next = R_IDLE;
  end

  assign sm_arready = (r_state == R_IDLE) && reset_n;
  assign sm_rvalid  = (r_state == R_DATA);
  assign sm_rdata   = rdata_q;
  assign sm_rresp   = rresp_q;

  // The display stores the raw word; segment decode happens per digit below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      disp_q  <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata_q <= in_range(ms_araddr) ? mem[ms_araddr] : '0;
        rresp_q <= in_range(ms_araddr) ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs && rresp_q == RESP_OKAY) disp_q <= rdata_q;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_digit u_seg (
      .nibble(disp_q[4*g +: 4]),
      .seg   (disp_hex[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_axi_lite_mem_disp.sv
// Self-checking bench for axi_lite_mem_disp (DEPTH=12) against an array model.
module tb_axi_lite_mem_disp;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic [8*(DW/4)-1:0] disp_hex;

  int checks = 0;
  int errors = 0;

  logic [7:0]    seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [DW-1:0] mem_m [DP];
  logic [DW-1:0] disp_m;

  always #5 clk = ~clk;

  axi_lite_mem_disp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n),
    .ms_awvalid(awvalid), .sm_awready(awready), .ms_awaddr(awaddr),
    .ms_wvalid(wvalid), .sm_wready(wready), .ms_wdata(wdata),
    .sm_bvalid(bvalid), .ms_bready(bready), .sm_bresp(bresp),
    .ms_arvalid(arvalid), .sm_arready(arready), .ms_araddr(araddr),
    .sm_rvalid(rvalid), .ms_rready(rready), .sm_rdata(rdata), .sm_rresp(rresp),
    .disp_hex(disp_hex)
  );

  function automatic logic [15:0] exp_disp(input logic [DW-1:0] v);
    logic [15:0] r;
    for (int i = 0; i < DW / 4; i++) r[8*i +: 8] = seg_tab[v[4*i +: 4]];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) mem_m[i] = DW'(i);
    disp_m = '0;
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
  task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int skew, input int bhold);
    logic [1:0] eresp;
    int n;
    eresp = (int'(a) < DP) ? 2'b00 : 2'b10;
    @(negedge clk);
    awaddr = a; wdata = d;
    if (skew == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      if (skew > 0) wvalid = 1'b1; else awvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      awaddr = ~a; wdata = ~d;
      n = (skew > 0) ? skew : -skew;
      for (int k = 0; k < n; k++) begin
        checks++;
        if (awready !== (skew > 0) || wready !== (skew < 0) || bvalid !== 1'b0) begin
          errors++;
          $display("FAIL wait_ready: aw=%b w=%b b=%b skew=%0d", awready, wready, bvalid, skew);
        end
        if (k < n - 1) @(negedge clk);
      end
      awaddr = a; wdata = d;
      if (skew > 0) awvalid = 1'b1; else wvalid = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (int'(a) < DP) mem_m[a] = d;
    checks++;
    if (bvalid !== 1'b1 || bresp !== eresp) begin
      errors++;
      $display("FAIL bresp: bvalid=%b bresp=%b expected 1/%b", bvalid, bresp, eresp);
    end
    for (int k = 0; k < bhold; k++) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = 4'h0; wdata = 8'hEE;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== eresp || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL bhold: b=%b resp=%b aw=%b w=%b expected 1/%b/0/0",
                 bvalid, bresp, awready, wready, eresp);
      end
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL bdone: b=%b aw=%b w=%b expected 0/1/1", bvalid, awready, wready);
    end
  endtask

  task automatic read_txn(input logic [AW-1:0] a, input int rhold);
    logic [DW-1:0] ed;
    logic [1:0]    er;
    ed = (int'(a) < DP) ? mem_m[a] : '0;
    er = (int'(a) < DP) ? 2'b00 : 2'b10;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL arready_idle: got %b expected 1", arready);
    end
    arvalid = 1'b1; araddr = a;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; araddr = ~a;
    for (int k = 0; k <= rhold; k++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || arready !== 1'b0) begin
        errors++;
        $display("FAIL rdata[%0h]: v=%b data=%h resp=%b ar=%b expected 1/%h/%b/0",
                 a, rvalid, rdata, rresp, arready, ed, er);
      end
      if (k < rhold) begin @(posedge clk); @(negedge clk); end
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    if (er == 2'b00) disp_m = ed;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || disp_hex !== exp_disp(disp_m)) begin
      errors++;
      $display("FAIL rdone_disp: v=%b ar=%b disp=%h expected 0/1/%h",
               rvalid, arready, disp_hex, exp_disp(disp_m));
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: aw=%b w=%b ar=%b b=%b r=%b expected all 0",
               awready, wready, arready, bvalid, rvalid);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 ||
        rvalid !== 1'b0 || rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00 ||
        disp_hex !== 16'h0303) begin
      errors++;
      $display("FAIL after_reset: aw=%b w=%b ar=%b b=%b r=%b rd=%h disp=%h expected 1/1/1/0/0/00/0303",
               awready, wready, arready, bvalid, rvalid, rdata, disp_hex);
    end
  endtask

  task automatic test_basic();
    read_txn(4'd5, 0);
    checks++;
    if (disp_hex !== 16'h0349) begin
      errors++;
      $display("FAIL disp5: got %h expected 0349", disp_hex);
    end
    write_txn(4'd3, 8'hAB, 0, 0);
    read_txn(4'd3, 1);
    checks++;
    if (disp_hex !== 16'h11C1) begin
      errors++;
      $display("FAIL dispAB: got %h expected 11c1", disp_hex);
    end
  endtask

  task automatic test_split_write();
    write_txn(4'd9, 8'h5A, 3, 4);
    read_txn(4'd9, 0);
    write_txn(4'd2, 8'hC7, -2, 1);
    read_txn(4'd2, 0);
    read_txn(4'd0, 0);
  endtask

  task automatic test_slverr();
    logic [15:0] d_before;
    d_before = disp_hex;
    write_txn(4'd14, 8'h77, 0, 0);
    write_txn(4'd12, 8'h66, 1, 0);
    read_txn(4'd14, 0);
    checks++;
    if (disp_hex !== d_before) begin
      errors++;
      $display("FAIL disp_slverr: got %h expected %h", disp_hex, d_before);
    end
    read_txn(4'd11, 0);
    read_txn(4'd12, 0);
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] old;
    old = mem_m[7];
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 4'd7; wdata = 8'h3C;
    arvalid = 1'b1; araddr = 4'd7;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mem_m[7] = 8'h3C;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old || bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL same_edge: rv=%b rd=%h bv=%b br=%b expected 1/%h/1/00",
               rvalid, rdata, bvalid, bresp, old);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    disp_m = old;
    read_txn(4'd7, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awvalid = 1'b1; awaddr = 4'd7; arvalid = 1'b1; araddr = 4'd7;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: aw=%b w=%b rv=%b expected 0/1/1", awready, wready, rvalid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || disp_hex !== 16'h0303) begin
      errors++;
      $display("FAIL mid_reset: bv=%b rv=%b disp=%h expected 0/0/0303", bvalid, rvalid, disp_hex);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || disp_hex !== 16'h0303) begin
      errors++;
      $display("FAIL post_reset: aw=%b w=%b ar=%b disp=%h expected 1/1/1/0303",
               awready, wready, arready, disp_hex);
    end
    read_txn(4'd7, 0);
    read_txn(4'd3, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 15));
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1)
        write_txn(a, d, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      else
        read_txn(a, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < DP; i++) read_txn(AW'(i), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_write();
    test_slverr();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_disp.md
# axi_lite_mem_disp

Parametrised AXI-Lite slave: register-file memory with independent read and write channels, full write-response channel, range-checked addressing, and a multi-digit seven-segment display driven by the last successful read. Next-generation memory/display slave for the board top level; sits between the switch/button master stub and the LED/7-seg pins.

## Interface
- DATA_W, 8, data width in bits; multiple of 4, range 4–32
- ADDR_W, 4, address width in bits
- DEPTH, 16, implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W
- DIGITS, DATA_W/4, derived display digit count; not overridden
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ms_awvalid / sm_awready  in / out  1  write-address handshake
- ms_awaddr  in  ADDR_W  write address
- ms_wvalid / sm_wready  in / out  1  write-data handshake
- ms_wdata  in  DATA_W  write data
- sm_bvalid / ms_bready  out / in  1  write-response handshake
- sm_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- ms_arvalid / sm_arready  in / out  1  read-address handshake
- ms_araddr  in  ADDR_W  read address
- sm_rvalid / ms_rready  out / in  1  read-data handshake
- sm_rdata  out  DATA_W  read data
- sm_rresp  out  2  as sm_bresp
- disp_hex  out  8*DIGITS  digit i in bits [8i+7:8i] shows nibble i of last OKAY read

## Operation
- Memory: DEPTH × DATA_W. On reset, word i = i mod 2**DATA_W.
- Address ≥ DEPTH → SLVERR. Write: memory unchanged. Read: sm_rdata = 0, disp_hex unchanged.
- Write FSM states: W_IDLE, W_ADDR (data held, waiting AW), W_DATA (address held, waiting W), W_RESP.
  - W_IDLE: awready = wready = 1. AW and W both fire → commit, W_RESP. AW only → latch addr, W_DATA. W only → latch data, W_ADDR.
  - W_ADDR: awready = 1, wready = 0. W_DATA: awready = 0, wready = 1. Completing handshake → commit, W_RESP.
  - W_RESP: bvalid = 1, bresp held stable. Leave to W_IDLE on bready.
- Read FSM states: R_IDLE (arready = 1) and R_DATA (rvalid = 1). AR handshake captures word (or 0) and resp into registers → R_DATA. rdata/rresp held until rready, then R_IDLE.
- Display: on R handshake with OKAY, disp_hex is loaded with per-nibble active-low segment codes, bit order a,b,c,d,e,f,g,dp with dp off.
  - Codes 0–F: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09, 11, C1, 63, 85, 61, 71 (hex).
- Read and write channels are fully independent; each carries at most one outstanding transaction.

## Timing
- Reset values: all ready/valid = 0 while reset_n is low. After release: awready = wready = arready = 1. bresp = rresp = 0, rdata = 0, disp_hex = all digits 8'h03 ("0").
- Read latency: AR handshake at edge N → rvalid = 1 after edge N. Next AR accepted at the edge after the R handshake, giving a 1-cycle bubble.
- Write: commit at the completing handshake edge N. bvalid = 1 after edge N. Next AW/W accepted the cycle after the B handshake.
- Read and write to the same address at the same edge: the read returns the old value.
- valid held without ready: state and outputs held indefinitely, with no timeout.
- reset_n asserted mid-transaction: transaction dropped. Memory reinitialised, FSMs return to idle, display returns to "0".

## Structure
- Shared package axi_disp_pkg: resp constants (RESP_OKAY, RESP_SLVERR), FSM state enums, function seg7_encode(nibble) → 8-bit code.
- One sub-module seg7_digit: nibble in, 8-bit segment code out, combinational. Instantiated DIGITS times by generate.

## Test plan
- Reset release → arready = awready = wready = 1, disp_hex = 8'h03 per digit. Read addr 5 → rdata 5, rresp 00, disp_hex = 8'h49.
- AW and W same cycle: addr 3, data 8'hAB → bvalid next cycle, bresp 00. Read addr 3 → 8'hAB, disp_hex = {8'h11 (A), 8'hC1 (b)}.
- W leads AW by 3 cycles and B is held 4 cycles with bready low → single commit, bresp stable, no second accept until bready.
- Param DEPTH=12: write addr 14 → bresp 10, memory unchanged. Read addr 14 → rresp 10, rdata 0, display unchanged.
- Write addr 7 = 8'h3C committing on the same edge as AR to addr 7 → rdata 7. Follow-up read → 8'h3C.
- reset_n pulsed low while in W_DATA and R_DATA → bvalid = rvalid = 0, word 7 back to 7, display "0".
